// File: rtl/skinny_sbox8_ti2_layer_seq_if.sv
// Port bundle between the SubCells layer sequencer and its environment (round controller, TI S-box, randomness).
// The slave modport is the sequencer side. The master modport is the side that drives start, state, S-box output and randomness.
interface skinny_sbox8_ti2_layer_seq_if #(
    parameter int RW = 32
) ();
    logic           start;
    logic [383:0]   s_in;
    logic           busy;
    logic           done;
    logic [383:0]   s_out;
    logic [23:0]    sbox_x;
    logic [RW-1:0]  sbox_r;
    logic [23:0]    sbox_y;
    logic [RW-1:0]  rnd_in;
    logic [63:0]    seed;
    logic           seed_ld;

    modport master (
        output start, s_in, sbox_y, rnd_in, seed, seed_ld,
        input  busy, done, s_out, sbox_x, sbox_r
    );

    modport slave (
        input  start, s_in, sbox_y, rnd_in, seed, seed_ld,
        output busy, done, s_out, sbox_x, sbox_r
    );
endinterface

// File: rtl/skinny_sbox8_ti2_layer_seq.sv
// Streams a 3-share 128-bit state byte by byte through one non-pipelined TI S-box and writes the output shares back.
// Latency: 16*(SBOX_LAT+1)+1 cycles from the accepted start to the done pulse. No backpressure; start is ignored while busy.
// The internal PRNG is built only when SKINNY_TI2_PRNG_EN is defined. Otherwise sbox_r is rnd_in delayed by one register.
module skinny_sbox8_ti2_layer_seq #(
    parameter int SBOX_LAT = 4,
    parameter int RW       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    skinny_sbox8_ti2_layer_seq_if.slave     io
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LAT = 4'(SBOX_LAT);

    state_t       state;
    logic [127:0] w0, w1, w2;
    logic [3:0]   idx;
    logic [3:0]   wcnt;
    logic [3:0]   nidx;

    assign nidx = idx + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            idx       <= '0;
            wcnt      <= '0;
            io.busy   <= 1'b0;
            io.done   <= 1'b0;
            io.s_out  <= '0;
            io.sbox_x <= '0;
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        w0        <= io.s_in[127:0];
                        w1        <= io.s_in[255:128];
                        w2        <= io.s_in[383:256];
                        idx       <= '0;
                        wcnt      <= '0;
                        io.sbox_x <= {io.s_in[263:256], io.s_in[135:128], io.s_in[7:0]};
                        io.busy   <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (wcnt == LAT) begin
                        // Each share path stays separate: sh0 goes back to share0, and so on.
                        w0[{idx, 3'b000} +: 8] <= io.sbox_y[7:0];
                        w1[{idx, 3'b000} +: 8] <= io.sbox_y[15:8];
                        w2[{idx, 3'b000} +: 8] <= io.sbox_y[23:16];
                        wcnt <= '0;
                        if (idx == 4'd15) begin
                            state <= DONE;
                        end else begin
                            idx       <= nidx;
                            io.sbox_x <= {w2[{nidx, 3'b000} +: 8],
                                          w1[{nidx, 3'b000} +: 8],
                                          w0[{nidx, 3'b000} +: 8]};
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                DONE: begin
                    io.s_out <= {w2, w1, w0};
                    io.done  <= 1'b1;
                    io.busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SKINNY_TI2_PRNG_EN
    localparam logic [63:0] PRNG_INIT = 64'h0123_4567_89AB_CDEF;

    logic [63:0] lfsr;
    logic        unused_ok;

    // Galois LFSR for x^64+x^4+x^3+x+1, advanced RW steps per clock.
    function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < RW; i++) begin
            t = {t[62:0], 1'b0} ^ (t[63] ? 64'h1B : 64'h0);
        end
        return t;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= PRNG_INIT;
        end else if (io.seed_ld) begin
            lfsr <= (io.seed == 64'h0) ? PRNG_INIT : io.seed;
        end else begin
            lfsr <= lfsr_adv(lfsr);
        end
    end

    assign io.sbox_r = lfsr[RW-1:0];
    assign unused_ok = ^io.rnd_in;
`else
    logic [RW-1:0] rnd_q;
    logic          unused_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q <= '0;
        end else begin
            rnd_q <= io.rnd_in;
        end
    end

    assign io.sbox_r = rnd_q;
    assign unused_ok = ^{io.seed, io.seed_ld};
`endif
endmodule

// File: tb/tb_skinny_sbox8_ti2_layer_seq.sv
// Directed bench for skinny_sbox8_ti2_layer_seq. It uses an unmasked SKINNY S8 model with SBOX_LAT register stages.
// The model re-shares its output with fixed masks so that share routing can be observed in s_out.
module tb_skinny_sbox8_ti2_layer_seq;
    localparam int SBOX_LAT = 4;
    localparam int RW       = 32;
    localparam logic [7:0] K1 = 8'h3C;
    localparam logic [7:0] K2 = 8'hC3;
    localparam logic [63:0] PINIT = 64'h0123_4567_89AB_CDEF;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    skinny_sbox8_ti2_layer_seq_if #(.RW(RW)) io ();

    skinny_sbox8_ti2_layer_seq #(.SBOX_LAT(SBOX_LAT), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First row of the SKINNY 8-bit S-box. Stimulus keeps recombined bytes in 0x00..0x0F.
    function automatic logic [7:0] s8(input logic [7:0] x);
        case (x[3:0])
            4'h0: s8 = 8'h65;  4'h1: s8 = 8'h4C;  4'h2: s8 = 8'h6A;  4'h3: s8 = 8'h42;
            4'h4: s8 = 8'h4B;  4'h5: s8 = 8'h63;  4'h6: s8 = 8'h43;  4'h7: s8 = 8'h6B;
            4'h8: s8 = 8'h55;  4'h9: s8 = 8'h75;  4'hA: s8 = 8'h5A;  4'hB: s8 = 8'h7A;
            4'hC: s8 = 8'h53;  4'hD: s8 = 8'h73;  4'hE: s8 = 8'h5B;  default: s8 = 8'h7B;
        endcase
    endfunction

    logic [7:0] pipe [SBOX_LAT];
    always @(posedge clk) begin
        pipe[0] <= io.sbox_x[7:0] ^ io.sbox_x[15:8] ^ io.sbox_x[23:16];
        for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign io.sbox_y = {K2, K1, s8(pipe[SBOX_LAT-1]) ^ K1 ^ K2};

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [383:0] exp_out(input logic [127:0] e);
        return {{16{K2}}, {16{K1}}, e ^ {16{K1 ^ K2}}};
    endfunction

    task automatic run_pass(input string tag, input logic [383:0] sin, input logic [127:0] e,
                            input int p1, input int p2);
        int cyc, lat, nd, xbad, bbad, rbad, b;
        logic [RW-1:0] rprev;
        logic [23:0]   xe;
        io.s_in   = sin;
        io.start  = 1'b1;
        rprev     = RW'($urandom);
        io.rnd_in = rprev;
        @(negedge clk);
        io.start = 1'b0;
        cyc = 0; lat = -1; nd = 0; xbad = 0; bbad = 0; rbad = 0;
        while (cyc < 120) begin
            if (cyc < 80) begin
                b  = cyc / 5;
                xe = {sin[256+8*b +: 8], sin[128+8*b +: 8], sin[8*b +: 8]};
                if (io.sbox_x !== xe) xbad++;
            end
            if (io.busy !== 1'(cyc <= 80)) bbad++;
            if (io.sbox_r !== rprev) rbad++;
            rprev     = RW'($urandom);
            io.rnd_in = rprev;
            io.start  = 1'(cyc == p1 || cyc == p2);
            @(negedge clk);
            cyc++;
            if (io.done === 1'b1) begin
                nd++;
                if (lat < 0) lat = cyc;
            end
        end
        io.start = 1'b0;
        chk({tag, "_latency"}, 384'(lat), 384'd81);
        chk({tag, "_done_count"}, 384'(nd), 384'd1);
        chk({tag, "_sbox_x_seq_errs"}, 384'(xbad), 384'd0);
        chk({tag, "_busy_errs"}, 384'(bbad), 384'd0);
`ifndef SKINNY_TI2_PRNG_EN
        chk({tag, "_sbox_r_delay_errs"}, 384'(rbad), 384'd0);
`endif
        chk({tag, "_s_out"}, io.s_out, exp_out(e));
        chk({tag, "_recombined"}, 384'(io.s_out[127:0] ^ io.s_out[255:128] ^ io.s_out[383:256]), 384'(e));
    endtask

`ifdef SKINNY_TI2_PRNG_EN
    function automatic logic [63:0] prng_next(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < RW; i++) t = {t[62:0], 1'b0} ^ (t[63] ? 64'h1B : 64'h0);
        return t;
    endfunction
`endif

    typedef struct {
        logic [127:0] s1;
        logic [127:0] s2;
        logic [127:0] pt;
        logic [127:0] e;
        int           p1;
        int           p2;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        logic [383:0] sin;
        logic [RW-1:0] refq [21];
        int c, dbad;
        n_chk = 0;
        n_fail = 0;

        vecs[0] = '{ {16{8'hA5}}, {16{8'hA5}}, 128'h0, {16{8'h65}}, -1, -1 };
        vecs[1] = '{ 128'h0, 128'h0, 128'h0F0E0D0C0B0A09080706050403020100,
                     128'h7B5B73537A5A75556B43634B426A4C65, -1, -1 };
        vecs[2] = '{ 128'h0123456789ABCDEFFEDCBA9876543210, 128'h5A5A5A5AC3C3C3C33C3C3C3CA5A5A5A5,
                     128'h000102030405060708090A0B0C0D0E0F,
                     128'h654C6A424B63436B55755A7A53735B7B, 10, 40 };
        vecs[3] = '{ 128'hDEADBEEF00112233CAFEF00D44556677, 128'h13579BDF2468ACE0FEEDFACE8899AABB,
                     {16{8'h07}}, {16{8'h6B}}, -1, -1 };

        rst = 1'b1;
        io.start = 1'b0; io.s_in = '0; io.rnd_in = '0; io.seed = '0; io.seed_ld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 384'(io.busy), 384'd0);
        chk("rst_done", 384'(io.done), 384'd0);
        chk("rst_s_out", io.s_out, 384'd0);
        chk("rst_sbox_x", 384'(io.sbox_x), 384'd0);
`ifdef SKINNY_TI2_PRNG_EN
        chk("rst_sbox_r", 384'(io.sbox_r), 384'(PINIT[RW-1:0]));
        refq[0] = io.sbox_r;
`else
        chk("rst_sbox_r", 384'(io.sbox_r), 384'd0);
        refq[0] = '0;
`endif
        rst = 1'b0;

`ifdef SKINNY_TI2_PRNG_EN
        begin
            logic [63:0] m;
            logic [RW-1:0] prev;
            m = PINIT;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                refq[k] = io.sbox_r;
                m = prng_next(m);
                chk("prng_step", 384'(io.sbox_r), 384'(m[RW-1:0]));
            end
            io.seed = 64'h0; io.seed_ld = 1'b1;
            @(negedge clk);
            io.seed_ld = 1'b0;
            for (int k = 0; k <= 20; k++) begin
                chk("prng_zero_seed_replay", 384'(io.sbox_r), 384'(refq[k]));
                @(negedge clk);
            end
            dbad = 0;
            prev = io.sbox_r;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (io.sbox_r === prev || io.sbox_r === '0) dbad++;
                prev = io.sbox_r;
            end
            chk("prng_repeat_or_zero", 384'(dbad), 384'd0);
        end
`endif

        for (int v = 0; v < 4; v++) begin
            sin = {vecs[v].s2, vecs[v].s1, vecs[v].pt ^ vecs[v].s1 ^ vecs[v].s2};
            run_pass($sformatf("vec%0d", v), sin, vecs[v].e, vecs[v].p1, vecs[v].p2);
        end

        // Abort a pass with reset while s_out still holds the previous result.
        io.s_in  = {vecs[1].s2, vecs[1].s1, vecs[1].pt};
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 384'(io.busy), 384'd0);
        chk("midrst_s_out", io.s_out, 384'd0);
        chk("midrst_sbox_x", 384'(io.sbox_x), 384'd0);
        dbad = 0;
        for (int k = 0; k < 3; k++) begin
            if (io.done !== 1'b0) dbad++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < 90; k++) begin
            if (io.done !== 1'b0) dbad++;
            @(negedge clk);
        end
        chk("midrst_no_done", 384'(dbad), 384'd0);
        chk("midrst_s_out_after", io.s_out, 384'd0);
        run_pass("after_rst", {vecs[1].s2, vecs[1].s1, vecs[1].pt}, vecs[1].e, -1, -1);

        // Back-to-back passes: restart on the cycle after done.
        io.s_in  = {vecs[3].s2, vecs[3].s1, vecs[3].pt ^ vecs[3].s1 ^ vecs[3].s2};
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        c = 0;
        while (io.done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_first_latency", 384'(c), 384'd81);
        chk("b2b_first_s_out", io.s_out, exp_out(vecs[3].e));
        io.s_in  = {vecs[1].s2, vecs[1].s1, vecs[1].pt};
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        c = 1;
        while (io.done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_done_spacing", 384'(c), 384'd82);
        chk("b2b_second_s_out", io.s_out, exp_out(vecs[1].e));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/skinny_sbox8_ti2_layer_seq.md
# skinny_sbox8_ti2_layer_seq

Sequencer for the SubCells layer of the three-share threshold-implemented SKINNY-128-384+ datapath. It takes a 128-bit state held as three Boolean shares and streams it byte by byte through one external, non-pipelined 8-bit TI S-box. It holds each input byte stable for the S-box's full register depth and supplies fresh randomness every cycle. It then writes the S-box output shares back into the state and reports completion to the round controller.

## Interface
- `SBOX_LAT`, default 4: number of register stages in the attached S-box (legal 1..15).
- `RW`, default 32: randomness bits the S-box consumes per cycle (legal 1..64).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a layer pass; sampled only in IDLE.
- `s_in` in 384: input state `{share2, share1, share0}`, each share 128 bits; byte i of a share is `[8i+7:8i]`.
- `busy` out 1: high while the pass runs.
- `done` out 1: one-cycle pulse when `s_out` is complete.
- `s_out` out 384: result state, same packing as `s_in`; held until the next pass completes.
- `sbox_x` out 24: S-box input shares `{sh2, sh1, sh0}` for the current byte.
- `sbox_r` out RW: randomness to the S-box, refreshed every cycle.
- `sbox_y` in 24: S-box output shares, same packing as `sbox_x`.
- `rnd_in` in RW: external randomness; used only when the PRNG is compiled out.
- `seed` in 64: PRNG seed; used only when the PRNG is compiled in.
- `seed_ld` in 1: loads `seed` into the PRNG; used only when the PRNG is compiled in.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - On `start=1`, load `s_in` into the working register, set `idx=0` and `wcnt=0`, then go to RUN.
  - `start=0` keeps IDLE.
- **RUN**
  - `sbox_x` is byte `idx` of each working share, driven from a register.
  - `wcnt` increments every cycle.
  - When `wcnt==SBOX_LAT`:
    - Write `sbox_y` into byte `idx` of the working shares (sh0 into share0, and so on).
    - Clear `wcnt`.
    - If `idx==15`, go to DONE; otherwise increment `idx`.
- **DONE**
  - Copy the working register to `s_out`.
  - Pulse `done` for one cycle.
  - Return to IDLE.
- `start` is ignored while in RUN or DONE. No queuing.
- Shares are never combined inside the block. Every share path stays separate from input to output.
- `sbox_x` changes only on the `wcnt==SBOX_LAT` edge, so the S-box input is stable for exactly `SBOX_LAT+1` cycles.
- `idx` is 4 bits and `wcnt` is 4 bits; neither wraps inside a pass.

## Timing
- Reset values: `busy=0`, `done=0`, `s_out=0`, `sbox_x=0`, `idx=0`, `wcnt=0`. `sbox_r` is 0 with the PRNG out, or the PRNG reset constant with it in.
- `busy` goes high on the cycle after `start` is accepted and falls in the same cycle `done` rises.
- Latency from the `start` edge to the `done` pulse is `16*(SBOX_LAT+1)+1` cycles: 81 for `SBOX_LAT=4`.
- `s_out` updates on the same edge that raises `done`.
- Reset mid-pass:
  - The pass is aborted immediately and all state returns to reset values.
  - No `done` pulse is produced, and a partially processed state is never exposed.

## Configuration
- `SKINNY_TI2_PRNG_EN` defined:
  - An internal 64-bit Galois LFSR with polynomial x^64+x^4+x^3+x+1 is unrolled RW steps per clock; `sbox_r` is its low RW bits.
  - The LFSR advances every cycle, including in IDLE.
  - Its reset value is `64'h0123_4567_89AB_CDEF`.
  - `seed_ld` loads `seed` on the next edge. A zero `seed` loads the reset constant instead.
  - `rnd_in` is unused.
- `SKINNY_TI2_PRNG_EN` undefined:
  - `sbox_r` is `rnd_in`, registered with one-cycle delay.
  - `seed` and `seed_ld` are unused.

## Test plan
- Zero state: bench uses an unmasked S-box model with `SBOX_LAT` delay. Drive `s_in` with share0=0 and share1=share2=`128'hA5..A5`, then start. Required: `done` at cycle 81, and the XOR of the `s_out` shares is all bytes `0x65`.
- Byte order: set share0 byte i = i and the other shares to 0, then start. Required: the recombined `s_out` byte i equals S8(i) for i = 0..15, and the `sbox_x` sh0 sequence is 0x00..0x0F, each value held 5 cycles.
- Start while busy: pulse `start` at cycles 10 and 40 of a pass. Required: both pulses ignored, a single `done` at 81, and `s_out` unchanged afterwards.
- Reset mid-pass: assert `rst` at cycle 30. Required: `busy=0`, `s_out=0` and `sbox_x=0` immediately, with no `done`. A fresh start after release completes normally in 81 cycles.
- PRNG, with the macro defined: `seed_ld` with `seed=0`. Required: `sbox_r` sequence equals the sequence from reset, no two consecutive `sbox_r` values are equal over 1000 cycles, and the value is never all-zero.
- Back-to-back passes: assert `start` the cycle after `done`. Required: accepted, with a second `done` exactly 82 cycles after the first.
